mxu_stream_frontend: RTL and testbench

Hardware host for the `multiplier` matrix unit. It takes a byte-serial operand stream, A row-major then B row-major, and assembles it into the packed `in0`/`in1` operand buses. It then launches the multiplier, captures `out` when `finished` rises, and streams Y back out row-major. It sits between a valid/ready element stream (DMA or host bridge) and one `multiplier` instance.

---
 rtl/mxu_pkg.sv | 17 +
 rtl/mxu_stream_frontend_if.sv | 34 +++
 rtl/mxu_y_serializer.sv | 70 +++++++
 rtl/mxu_stream_frontend.sv | 134 +++++++++++++
 tb/tb_mxu_stream_frontend.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mxu_pkg.sv
// Shared types for the matrix-unit stream frontend: FSM state enum and an index-width helper.
package mxu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT,
    ST_DRAIN
  } mxu_fe_state_t;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int mxu_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mxu_stream_frontend_if.sv
// Bundle of the element streams, multiplier operand/result buses and status flags of the frontend.
interface mxu_stream_frontend_if #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
);
  localparam int MAT_W = DIM * DIM * WIDTH;

  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic [MAT_W-1:0] mxu_in0;
  logic [MAT_W-1:0] mxu_in1;
  logic             mxu_start;
  logic [MAT_W-1:0] mxu_out;
  logic             mxu_finished;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic             busy;
  logic             err;

  // Host / DMA / multiplier side of the bundle.
  modport master (
    output s_valid, s_data, mxu_out, mxu_finished, m_ready,
    input  s_ready, mxu_in0, mxu_in1, mxu_start, m_valid, m_data, m_last, busy, err
  );

  // Frontend side of the bundle.
  modport slave (
    input  s_valid, s_data, mxu_out, mxu_finished, m_ready,
    output s_ready, mxu_in0, mxu_in1, mxu_start, m_valid, m_data, m_last, busy, err
  );
endinterface

// File: rtl/mxu_y_serializer.sv
// Holds a captured Y matrix and streams it out row-major over valid/ready, pulsing done_o on the final handshake.
module mxu_y_serializer
  import mxu_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       capture_i,
  input  logic [DIM*DIM*WIDTH-1:0]   y_i,
  input  logic                       m_ready_i,
  output logic                       m_valid_o,
  output logic [WIDTH-1:0]           m_data_o,
  output logic                       m_last_o,
  output logic                       done_o
);
  localparam int NELEM = DIM * DIM;
  localparam int JW    = mxu_idx_width(NELEM);
  localparam logic [JW-1:0] J_LAST = JW'(NELEM - 1);

  logic [NELEM*WIDTH-1:0] y_q, y_d;
  logic [JW-1:0]          j_q, j_d;
  logic                   active_q, active_d;
  logic                   handshake;

  assign handshake = active_q && m_ready_i;
  assign m_valid_o = active_q;
  assign m_last_o  = active_q && (j_q == J_LAST);
  assign done_o    = handshake && (j_q == J_LAST);

  always_comb begin
    y_d      = y_q;
    j_d      = j_q;
    active_d = active_q;
    if (capture_i) begin
      y_d      = y_i;
      j_d      = '0;
      active_d = 1'b1;
    end else if (handshake) begin
      if (j_q == J_LAST) begin
        j_d      = '0;
        active_d = 1'b0;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  // Output mux reads zero while idle so m_data is quiet outside a drain.
  always_comb begin
    m_data_o = '0;
    for (int e = 0; e < NELEM; e++) begin
      if (active_q && (j_q == JW'(e))) m_data_o = y_q[e*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q      <= '0;
      j_q      <= '0;
      active_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      j_q      <= j_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/mxu_stream_frontend.sv
// Byte-serial operand loader, launcher and result drainer for one matrix multiplier.
// Optional WAIT watchdog enabled by defining MXU_FE_TIMEOUT_EN.
module mxu_stream_frontend
  import mxu_pkg::*;
#(
  parameter int DIM            = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  reset,
  mxu_stream_frontend_if.slave bus
);
  localparam int NELEM = DIM * DIM;
  localparam int KW    = mxu_idx_width(2 * NELEM);
  localparam logic [KW-1:0] K_LAST = KW'(2 * NELEM - 1);

  // Row-major flattened matrix, element [r][c] at slot r*DIM+c.
  typedef logic [NELEM*WIDTH-1:0] mat_t;

  mxu_fe_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  mat_t          a_q, b_q;
  logic          accept, capture, yDone, timeout;

  assign accept      = (state_q == ST_LOAD) && bus.s_valid;
  assign bus.mxu_in0 = a_q;
  assign bus.mxu_in1 = b_q;
  assign bus.busy    = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) || (state_q == ST_DRAIN) ||
                       ((state_q == ST_LOAD) && (k_q != '0));

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    bus.s_ready   = 1'b0;
    bus.mxu_start = 1'b0;
    capture       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        bus.s_ready = 1'b1;
        if (accept) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = ST_LAUNCH;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        bus.mxu_start = 1'b1;
        state_d       = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mxu_finished) begin
          capture = 1'b1;
          state_d = ST_DRAIN;
        end else if (timeout) begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: if (yDone) state_d = ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Indices below NELEM land in A, the rest in B; both stay put until the next job overwrites them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      for (int e = 0; e < NELEM; e++) begin
        if (accept && (k_q == KW'(e)))         a_q[e*WIDTH +: WIDTH] <= bus.s_data;
        if (accept && (k_q == KW'(NELEM + e))) b_q[e*WIDTH +: WIDTH] <= bus.s_data;
      end
    end
  end

`ifdef MXU_FE_TIMEOUT_EN
  localparam int TW = mxu_idx_width(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;

  assign timeout = (wdog_q == TW'(TIMEOUT_CYCLES - 1));
  assign bus.err = err_q;

  always_comb begin
    wdog_d = (state_q == ST_WAIT) ? wdog_q + 1'b1 : '0;
    err_d  = err_q || ((state_q == ST_WAIT) && !bus.mxu_finished && timeout);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  mxu_y_serializer #(
    .DIM   (DIM),
    .WIDTH (WIDTH)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .capture_i (capture),
    .y_i       (bus.mxu_out),
    .m_ready_i (bus.m_ready),
    .m_valid_o (bus.m_valid),
    .m_data_o  (bus.m_data),
    .m_last_o  (bus.m_last),
    .done_o    (yDone)
  );

endmodule

// File: tb/tb_mxu_stream_frontend.sv
// Randomized self-checking bench for mxu_stream_frontend (DIM=2) with a 3-cycle multiplier model.
// Watchdog expectations follow MXU_FE_TIMEOUT_EN.
module tb_mxu_stream_frontend;
  localparam int DIM   = 2;
  localparam int WIDTH = 8;
  localparam int NE    = DIM * DIM;
  localparam int MW    = NE * WIDTH;
  localparam int TO    = 16;

  typedef byte unsigned bq_t[$];

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mxu_stream_frontend_if #(.DIM(DIM), .WIDTH(WIDTH)) bus ();

  mxu_stream_frontend #(
    .DIM            (DIM),
    .WIDTH          (WIDTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic          mulEnable = 1'b1;
  logic          mulFin    = 1'b0;
  logic          mulBusy   = 1'b0;
  logic          strayEn   = 1'b0;
  logic          strayFin  = 1'b0;
  logic [MW-1:0] mulY      = '0;
  logic [MW-1:0] junkY     = '0;
  int            pending   = 0;
  int            startPulses = 0;

  assign bus.mxu_finished = mulFin | strayFin;
  assign bus.mxu_out      = mulFin ? mulY : junkY;

  // Multiplier model reading the packed [row][col] operand buses.
  function automatic logic [MW-1:0] matMul(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] y;
    int acc;
    y = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        acc = 0;
        for (int k = 0; k < DIM; k++)
          acc += int'(a[(r*DIM+k)*WIDTH +: WIDTH]) * int'(b[(k*DIM+c)*WIDTH +: WIDTH]);
        y[(r*DIM+c)*WIDTH +: WIDTH] = acc[WIDTH-1:0];
      end
    return y;
  endfunction

  // Expected Y straight from the stream order: first NE bytes are A, next NE are B.
  function automatic bq_t refY(input bq_t v);
    bq_t y;
    int acc;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        acc = 0;
        for (int k = 0; k < DIM; k++) acc += v[r*DIM+k] * v[NE + k*DIM + c];
        y.push_back(byte'(acc % 256));
      end
    return y;
  endfunction

  function automatic bq_t randJob();
    bq_t v;
    for (int i = 0; i < 2*NE; i++) v.push_back(byte'($urandom_range(0, 255)));
    return v;
  endfunction

  initial begin : mulModel
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        pending = 0;
        mulFin  = 1'b0;
        mulBusy = 1'b0;
      end else begin
        if (mulFin) begin
          mulFin  = 1'b0;
          mulBusy = 1'b0;
        end
        if (bus.mxu_start) begin
          startPulses++;
          mulBusy = 1'b1;
          if (mulEnable) begin
            mulY    = matMul(bus.mxu_in0, bus.mxu_in1);
            pending = 3;
          end
        end else if (pending > 0) begin
          pending--;
          if (pending == 0) mulFin = 1'b1;
        end
      end
    end
  end

  // Stray finished pulses carry garbage and are kept out of the genuine WAIT window.
  initial begin : strayGen
    forever begin
      @(negedge clk);
      strayFin = strayEn && !mulBusy && ($urandom_range(0, 3) == 0);
      junkY    = MW'($urandom);
    end
  end

  task automatic sendStream(input bq_t v, input int bubblePct);
    int i = 0;
    int guard = 0;
    while (i < v.size() && guard < 1000) begin
      @(negedge clk);
      guard++;
      if ($urandom_range(0, 99) < bubblePct) begin
        bus.s_valid = 1'b0;
        bus.s_data  = WIDTH'($urandom);
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = v[i];
        if (bus.s_ready) i++;
      end
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    checks++;
    if (i != v.size()) begin
      errors++;
      $display("[TB] FAIL stream_timeout accepted %0d required %0d", i, v.size());
    end
  endtask

  task automatic collect(input int mode, output bq_t data, output bq_t lasts);
    int guard = 0;
    bit done = 0;
    logic rdy;
    data  = {};
    lasts = {};
    while (!done && guard < 200 && data.size() <= NE) begin
      @(negedge clk);
      guard++;
      rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.m_ready = rdy;
      if (bus.m_valid && rdy) begin
        data.push_back(bus.m_data);
        lasts.push_back(byte'(bus.m_last));
        if (bus.m_last) done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain_timeout elements %0d last_seen 0 required 1", data.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.mxu_start, bus.m_valid, bus.m_last, bus.busy, bus.err} !== 6'b0 ||
        bus.m_data !== '0 || bus.mxu_in0 !== '0 || bus.mxu_in1 !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got ready=%b start=%b mv=%b busy=%b in0=%h required all 0",
               bus.s_ready, bus.mxu_start, bus.m_valid, bus.busy, bus.mxu_in0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_ready_early got %b required 0", bus.s_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL release_ready got %b required 1", bus.s_ready);
    end
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = byte'(8'hA0 + i);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    checks++;
    if (bus.mxu_in0 !== 32'h00A2A1A0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL partial_load got in0=%h busy=%b required 00a2a1a0 1", bus.mxu_in0, bus.busy);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.mxu_in0 !== '0 || bus.busy !== 1'b0 || bus.s_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midstream_reset got in0=%h busy=%b ready=%b required 0 0 0",
               bus.mxu_in0, bus.busy, bus.s_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rerelease_ready got %b required 1", bus.s_ready);
    end
  endtask

  task automatic test_basic();
    bq_t v = '{1, 2, 3, 4, 5, 6, 7, 8};
    bq_t expY, d, l;
    int s0 = startPulses;
    int lat = 0;
    bus.m_ready = 1'b0;
    sendStream(v, 0);
    checks++;
    if (bus.mxu_start !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_start got start=%b busy=%b required 1 1", bus.mxu_start, bus.busy);
    end
    checks++;
    if (bus.mxu_in0 !== 32'h04030201 || bus.mxu_in1 !== 32'h08070605) begin
      errors++;
      $display("[TB] FAIL basic_operands got %h %h required 04030201 08070605", bus.mxu_in0, bus.mxu_in1);
    end
    while (!bus.m_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d required 4", lat);
    end
    collect(0, d, l);
    expY = refY(v);
    checks++;
    if (d.size() != NE) begin
      errors++;
      $display("[TB] FAIL basic_count got %0d required %0d", d.size(), NE);
    end
    for (int i = 0; i < d.size() && i < NE; i++) begin
      checks++;
      if (d[i] != expY[i] || l[i] != byte'(i == NE-1)) begin
        errors++;
        $display("[TB] FAIL basic_y%0d got %0d last=%0d required %0d last=%0d",
                 i, d[i], l[i], expY[i], (i == NE-1));
      end
    end
    checks++;
    if (startPulses - s0 != 1) begin
      errors++;
      $display("[TB] FAIL basic_start_pulses got %0d required 1", startPulses - s0);
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_return got ready=%b mv=%b busy=%b required 1 0 0",
               bus.s_ready, bus.m_valid, bus.busy);
    end
  endtask

  task automatic test_backpressure();
    bq_t v = randJob();
    bq_t expY = refY(v);
    bq_t got;
    logic prevValid = 1'b0, prevReady = 1'b1, prevLast = 1'b0, rdy = 1'b0;
    logic [WIDTH-1:0] prevData = '0;
    int guard = 0;
    bit done = 0;
    bus.m_ready = 1'b0;
    sendStream(v, 0);
    while (!done && guard < 100 && got.size() <= NE) begin
      @(negedge clk);
      guard++;
      if (bus.m_valid && prevValid && !prevReady) begin
        checks++;
        if (bus.m_data !== prevData || bus.m_last !== prevLast) begin
          errors++;
          $display("[TB] FAIL bp_hold got %0d last=%b required %0d last=%b",
                   bus.m_data, bus.m_last, prevData, prevLast);
        end
      end
      rdy = ~rdy;
      bus.m_ready = rdy;
      if (bus.m_valid && rdy) begin
        got.push_back(bus.m_data);
        if (bus.m_last) done = 1;
      end
      prevValid = bus.m_valid;
      prevReady = rdy;
      prevData  = bus.m_data;
      prevLast  = bus.m_last;
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++;
    if (!done || got.size() != NE) begin
      errors++;
      $display("[TB] FAIL bp_count got %0d done=%0d required %0d done=1", got.size(), done, NE);
    end
    for (int i = 0; i < got.size() && i < NE; i++) begin
      checks++;
      if (got[i] != expY[i]) begin
        errors++;
        $display("[TB] FAIL bp_y%0d got %0d required %0d", i, got[i], expY[i]);
      end
    end
  endtask

  task automatic test_stray();
    bq_t v, expY, d, l;
    strayEn = 1'b1;
    for (int job = 0; job < 2; job++) begin
      v = randJob();
      expY = refY(v);
      sendStream(v, 30);
      collect(2, d, l);
      @(negedge clk);
      bus.m_ready = 1'b0;
      checks++;
      if (d.size() != NE) begin
        errors++;
        $display("[TB] FAIL stray_count job%0d got %0d required %0d", job, d.size(), NE);
      end
      for (int i = 0; i < d.size() && i < NE; i++) begin
        checks++;
        if (d[i] != expY[i]) begin
          errors++;
          $display("[TB] FAIL stray_y job%0d idx%0d got %0d required %0d", job, i, d[i], expY[i]);
        end
      end
    end
    strayEn = 1'b0;
  endtask

  task automatic test_reset_drain();
    bq_t v = randJob();
    bq_t v2 = randJob();
    bq_t expY2 = refY(v2);
    bq_t d, l;
    int cnt = 0;
    int guard = 0;
    sendStream(v, 0);
    bus.m_ready = 1'b1;
    while (cnt < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
      if (bus.m_valid) cnt++;
    end
    @(posedge clk);
    #2;
    checks++;
    if (bus.m_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drain_before_reset mv got %b required 1", bus.m_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_data !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_reset got mv=%b last=%b data=%0d busy=%b required 0 0 0 0",
               bus.m_valid, bus.m_last, bus.m_data, bus.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.m_ready = 1'b0;
    sendStream(v2, 0);
    collect(0, d, l);
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++;
    if (d.size() != NE) begin
      errors++;
      $display("[TB] FAIL after_reset_count got %0d required %0d", d.size(), NE);
    end
    for (int i = 0; i < d.size() && i < NE; i++) begin
      checks++;
      if (d[i] != expY2[i]) begin
        errors++;
        $display("[TB] FAIL after_reset_y%0d got %0d required %0d", i, d[i], expY2[i]);
      end
    end
  endtask

  task automatic test_watchdog();
    bq_t v = randJob();
    mulEnable = 1'b0;
    bus.m_ready = 1'b1;
    sendStream(v, 0);
`ifdef MXU_FE_TIMEOUT_EN
    begin
      int cnt = 0;
      while (!bus.err && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      checks++;
      if (cnt != TO + 1) begin
        errors++;
        $display("[TB] FAIL wdog_cycles got %0d required %0d", cnt, TO + 1);
      end
      checks++;
      if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wdog_return got ready=%b mv=%b busy=%b required 1 0 0",
                 bus.s_ready, bus.m_valid, bus.busy);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (bus.err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL wdog_sticky got %b required 1", bus.err);
      end
    end
`else
    repeat (3 * TO) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.m_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wait_forever got busy=%b err=%b mv=%b required 1 0 0",
                 bus.busy, bus.err, bus.m_valid);
      end
    end
`endif
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wdog_clear got err=%b busy=%b required 0 0", bus.err, bus.busy);
    end
    reset = 1'b0;
    mulEnable = 1'b1;
    bus.m_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stray();
    test_reset_drain();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
